indexed_framebuffer: RTL and testbench

- Parametrised palette-indexed frame buffer that sits between game/draw logic and the VGA controller output stage.
- Accepts per-pixel writes through a valid/ready port.
- Provides a hardware clear engine that fills the whole buffer with one index.
- Scans out pixels at VGA rate through a writable colour palette.
- Replaces the single-mode mapper with configurable resolution, index width and optional double buffering.

---
 rtl/indexed_framebuffer.sv | 230 +++++++++++++++++++++++
 tb/tb_indexed_framebuffer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/indexed_framebuffer.sv
// indexed_framebuffer: palette-indexed frame buffer between draw logic and
// the VGA output stage. Pixel writes arrive on a valid/ready port, a clear
// engine fills the whole buffer with one index, and scan-out runs as a
// 2-stage pipeline (buffer read, then registered palette lookup).
// Optional feature macro: DOUBLE_BUFFER_EN (front/back banks with swap).
module indexed_framebuffer #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COORD_W = 10,
  parameter int IDX_W   = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               VGA_BLANK_N,
  input  logic               frame_start,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic               clr_start,
  input  logic [IDX_W-1:0]   clr_idx,
  output logic               clr_busy,
  input  logic               pal_we,
  input  logic [IDX_W-1:0]   pal_addr,
  input  logic [23:0]        pal_rgb,
  input  logic               swap_req,
  output logic               swap_pending,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B
);

  localparam int DEPTH  = H_RES * V_RES;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough for y*H_RES + x with any COORD_W-bit y and x, so an
  // out-of-range coordinate can never alias onto a valid address.
  localparam int FULL_W = COORD_W + $clog2(H_RES + 1) + 1;

`ifdef DOUBLE_BUFFER_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif
  localparam int MEM_W = (BANKS * DEPTH > 1) ? $clog2(BANKS * DEPTH) : 1;

  localparam logic [FULL_W-1:0] H_RES_F   = FULL_W'(H_RES);
  localparam logic [FULL_W-1:0] V_RES_F   = FULL_W'(V_RES);
  localparam logic [FULL_W-1:0] DEPTH_F   = FULL_W'(DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [MEM_W-1:0]  BANK_OFS  = MEM_W'(DEPTH);

  // Linear pixel address, computed at full width.
  function automatic logic [FULL_W-1:0] lin_addr(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    return FULL_W'(y) * H_RES_F + FULL_W'(x);
  endfunction

  // Coordinate is inside the visible frame (the address test is implied by
  // the x/y tests but keeps the full-width address honest).
  function automatic logic in_frame(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y,
                                    input logic [FULL_W-1:0]  a);
    return (FULL_W'(x) < H_RES_F) && (FULL_W'(y) < V_RES_F) && (a < DEPTH_F);
  endfunction

  // Physical RAM address for a word within a bank.
  function automatic logic [MEM_W-1:0] bank_addr(input logic              bank,
                                                 input logic [ADDR_W-1:0] a);
    return MEM_W'(a) + (bank ? BANK_OFS : '0);
  endfunction

  typedef enum logic {S_IDLE, S_CLEAR} clr_state_t;

  clr_state_t         state, state_nxt;
  logic               clr_load;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [IDX_W-1:0]   clr_val;

  logic               front_bank, back_bank;

  logic [FULL_W-1:0]  wr_lin, rd_lin;
  logic               wr_ok, rd_ok;
  logic [MEM_W-1:0]   rd_maddr;

  logic               mem_we;
  logic [MEM_W-1:0]   mem_waddr;
  logic [IDX_W-1:0]   mem_wdata;

  logic [IDX_W-1:0]   fb_mem  [BANKS*DEPTH];
  logic [23:0]        palette [2**IDX_W];

  logic [IDX_W-1:0]   idx_p1;
  logic               vld_p1;
  logic [23:0]        rgb_p2;

  assign wr_lin   = lin_addr(wr_x, wr_y);
  assign wr_ok    = in_frame(wr_x, wr_y, wr_lin);
  assign rd_lin   = lin_addr(DrawX, DrawY);
  assign rd_ok    = in_frame(DrawX, DrawY, rd_lin);
  assign rd_maddr = bank_addr(front_bank, rd_lin[ADDR_W-1:0]);

`ifdef DOUBLE_BUFFER_EN
  logic swap_pend_q;
  logic swap_go;

  // A swap may only happen at frame start and never while a clear is
  // filling the back bank; a same-cycle request counts immediately.
  assign swap_go = frame_start && (swap_pend_q || swap_req) && !clr_busy;

  // Bank role register and pending-swap flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      front_bank  <= 1'b0;
      swap_pend_q <= 1'b0;
    end else if (swap_go) begin
      front_bank  <= ~front_bank;
      swap_pend_q <= 1'b0;
    end else if (swap_req) begin
      swap_pend_q <= 1'b1;
    end
  end

  assign back_bank    = ~front_bank;
  assign swap_pending = swap_pend_q;
`else
  logic unused_swap;

  assign front_bank   = 1'b0;
  assign back_bank    = 1'b0;
  assign swap_pending = 1'b0;
  assign unused_swap  = swap_req ^ frame_start;
`endif

  // Clear FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Clear FSM next state; the write port is only open while idle.
  always_comb begin
    state_nxt = state;
    clr_load  = 1'b0;
    clr_busy  = 1'b0;
    wr_ready  = 1'b0;
    unique case (state)
      S_IDLE: begin
        wr_ready = 1'b1;
        if (clr_start) begin
          state_nxt = S_CLEAR;
          clr_load  = 1'b1;
        end
      end
      S_CLEAR: begin
        clr_busy = 1'b1;
        if (clr_cnt == CLR_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Clear address counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)      clr_cnt <= '0;
    else if (clr_load) clr_cnt <= '0;
    else if (clr_busy) clr_cnt <= clr_cnt + ADDR_W'(1);
  end

  // Fill index captured when a clear is accepted.
  always_ff @(posedge Clk) begin
    if (clr_load) clr_val <= clr_idx;
  end

  // Single RAM write port shared by the clear engine and the pixel port.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (clr_busy) begin
      mem_we    = 1'b1;
      mem_waddr = bank_addr(back_bank, clr_cnt);
      mem_wdata = clr_val;
    end else if (wr_valid && wr_ready && wr_ok) begin
      mem_we    = 1'b1;
      mem_waddr = bank_addr(back_bank, wr_lin[ADDR_W-1:0]);
      mem_wdata = wr_idx;
    end
  end

  // Buffer RAM write.
  always_ff @(posedge Clk) begin
    if (mem_we) fb_mem[mem_waddr] <= mem_wdata;
  end

  // Palette RAM; a same-cycle lookup still sees the previous entry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 2**IDX_W; i++) palette[i] <= '0;
    end else if (pal_we) begin
      palette[pal_addr] <= pal_rgb;
    end
  end

  // ---- stage 1: buffer read (out-of-frame reads as index 0) ----
  // Buffer read data.
  always_ff @(posedge Clk) begin
    idx_p1 <= rd_ok ? fb_mem[rd_maddr] : '0;
  end

  // Blank flag travelling with the pixel.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= VGA_BLANK_N;
  end

  // ---- stage 2: palette lookup, forced black during blanking ----
  // Registered colour output.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rgb_p2 <= '0;
    else          rgb_p2 <= vld_p1 ? palette[idx_p1] : 24'h0;
  end

  assign VGA_R = rgb_p2[23:16];
  assign VGA_G = rgb_p2[15:8];
  assign VGA_B = rgb_p2[7:0];

endmodule

// File: tb/tb_indexed_framebuffer.sv
// tb_indexed_framebuffer: directed bench for indexed_framebuffer with a
// frame-level reference model checked every cycle plus literal checks.
`timescale 1ns/1ps
module tb_indexed_framebuffer;

  localparam int H     = 32;
  localparam int V     = 24;
  localparam int CW    = 10;
  localparam int IW    = 4;
  localparam int DEPTH = H * V;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [CW-1:0] DrawX = CW'(700), DrawY = '0;
  logic          VGA_BLANK_N = 1'b0, frame_start = 1'b0;
  logic          wr_valid = 1'b0, wr_ready;
  logic [CW-1:0] wr_x = '0, wr_y = '0;
  logic [IW-1:0] wr_idx = '0, clr_idx = '0, pal_addr = '0;
  logic          clr_start = 1'b0, clr_busy, pal_we = 1'b0;
  logic [23:0]   pal_rgb = '0;
  logic          swap_req = 1'b0, swap_pending;
  logic [7:0]    VGA_R, VGA_G, VGA_B;

  int errors = 0;
  int checks = 0;

  indexed_framebuffer #(.H_RES(H), .V_RES(V), .COORD_W(CW), .IDX_W(IW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .VGA_BLANK_N(VGA_BLANK_N), .frame_start(frame_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_idx(wr_idx), .clr_start(clr_start), .clr_idx(clr_idx),
    .clr_busy(clr_busy), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_rgb(pal_rgb), .swap_req(swap_req), .swap_pending(swap_pending),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level view) ----------------
  int unsigned mem_m [2][DEPTH];
  logic [23:0] pal_m [16];
  logic [23:0] exp_rgb;
  bit          exp_vld1;
  int          exp_idx1;
  bit          busy_m, front_m, pend_m, model_init;
  int          cnt_m, clr_val_m;

  function automatic int pix(input int x, input int y);
    if (x < H && y < V) return y * H + x;
    return -1;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) pal_m[i] = 24'h0;
      exp_rgb = 24'h0; exp_vld1 = 1'b0; exp_idx1 = 0;
      busy_m = 1'b0; cnt_m = 0; pend_m = 1'b0; front_m = 1'b0;
      model_init = 1'b1;
    end else begin : step_blk
      int rp;
      int wp;
      bit was_busy;
      bit back;
      was_busy = busy_m;
`ifdef DOUBLE_BUFFER_EN
      back = !front_m;
`else
      back = 1'b0;
`endif
      // colour shown now comes from the pixel fetched one cycle ago
      exp_rgb  = exp_vld1 ? pal_m[exp_idx1] : 24'h0;
      rp       = pix(int'(DrawX), int'(DrawY));
      exp_idx1 = (rp < 0) ? 0 : int'(mem_m[front_m][rp]);
      exp_vld1 = VGA_BLANK_N;
      if (pal_we) pal_m[pal_addr] = pal_rgb;
      if (was_busy) begin
        mem_m[back][cnt_m] = clr_val_m;
        cnt_m++;
        if (cnt_m == DEPTH) busy_m = 1'b0;
      end else begin
        wp = pix(int'(wr_x), int'(wr_y));
        if (wr_valid && wp >= 0) mem_m[back][wp] = wr_idx;
        if (clr_start) begin
          busy_m = 1'b1; cnt_m = 0; clr_val_m = int'(clr_idx);
        end
      end
`ifdef DOUBLE_BUFFER_EN
      if (frame_start && (pend_m || swap_req) && !was_busy) begin
        front_m = !front_m; pend_m = 1'b0;
      end else if (swap_req) begin
        pend_m = 1'b1;
      end
`endif
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge Clk) begin
    #1;
    if (model_init) begin
      check("vga_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp_rgb});
      check("clr_busy", clr_busy, busy_m);
      check("wr_ready", wr_ready, !busy_m);
      check("swap_pending", swap_pending, pend_m);
    end
  end

  // ---------------- stimulus helpers (all start at a negedge) ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic put_pix(input int x, input int y, input int idx);
    wr_x = CW'(x); wr_y = CW'(y); wr_idx = IW'(idx); wr_valid = 1'b1;
    cyc(1);
    wr_valid = 1'b0;
  endtask

  task automatic put_pal(input int a, input logic [23:0] rgb);
    pal_addr = IW'(a); pal_rgb = rgb; pal_we = 1'b1;
    cyc(1);
    pal_we = 1'b0;
  endtask

  task automatic expect_pix(input int x, input int y, input logic [23:0] rgb, input string name);
    DrawX = CW'(x); DrawY = CW'(y); VGA_BLANK_N = 1'b1;
    cyc(2);
    check(name, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, rgb});
  endtask

  task automatic start_clear(input int idx);
    clr_idx = IW'(idx); clr_start = 1'b1;
    cyc(1);
    clr_start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (clr_busy && n < 2000) begin n++; cyc(1); end
    if (clr_busy) check("clear_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_swap(input bit req, input bit fs);
    swap_req = req; frame_start = fs;
    cyc(1);
    swap_req = 1'b0; frame_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int rdy_hi;
    cyc(3);
    check("reset_rgb", {VGA_R, VGA_G, VGA_B}, 32'h0);
    check("reset_busy", clr_busy, 32'd0);
    check("reset_swap_pending", swap_pending, 32'd0);
    Reset_n = 1'b1;
    cyc(1);
    check("post_reset_wr_ready", wr_ready, 32'd1);

`ifndef DOUBLE_BUFFER_EN
    // Clear with index 5; a second clr_start mid-clear must be ignored.
    put_pal(5, 24'h0055AA);
    start_clear(5);
    check("clear_busy_rises", clr_busy, 32'd1);
    check("clear_wr_ready_drops", wr_ready, 32'd0);
    n = 0; rdy_hi = 0;
    while (clr_busy && n < 2000) begin
      if (wr_ready) rdy_hi++;
      clr_start = (n == 300);
      clr_idx   = (n == 300) ? 4'd9 : 4'd5;
      n++;
      cyc(1);
    end
    clr_start = 1'b0;
    check("clear_cycles", n, DEPTH);
    check("clear_wr_ready_high_cycles", rdy_hi, 32'd0);
    for (int p = 0; p < DEPTH; p++) begin
      DrawX = CW'(p % H); DrawY = CW'(p / H); VGA_BLANK_N = 1'b1;
      cyc(1);
    end
    cyc(2);
    check("cleared_last_pixel", {VGA_R, VGA_G, VGA_B}, 32'h0055AA);

    // Basic write and scan latency.
    put_pal(3, 24'hFFCC66);
    put_pal(0, 24'h102030);
    put_pix(10, 20, 3);
    expect_pix(11, 20, 24'h0055AA, "neighbour_pixel");
    DrawX = CW'(10);
    cyc(1);
    check("latency_not_yet", {VGA_R, VGA_G, VGA_B}, 32'h0055AA);
    cyc(1);
    check("pix_R", VGA_R, 32'hFF);
    check("pix_G", VGA_G, 32'hCC);
    check("pix_B", VGA_B, 32'h66);

    // Out-of-range scan and writes.
    expect_pix(700, 20, 24'h102030, "oor_scan");
    wr_x = CW'(32); wr_y = '0; wr_idx = 4'd7; wr_valid = 1'b1;
    #1 check("oor_write_ready", wr_ready, 32'd1);
    cyc(1);
    wr_x = CW'(640);
    cyc(1);
    wr_valid = 1'b0;
    expect_pix(0, 1, 24'h0055AA, "oor_write_no_alias");

    // One-cycle blank.
    DrawX = CW'(10); DrawY = CW'(20); VGA_BLANK_N = 1'b1;
    cyc(3);
    VGA_BLANK_N = 1'b0;
    cyc(1);
    VGA_BLANK_N = 1'b1;
    check("blank_before", {VGA_R, VGA_G, VGA_B}, 32'hFFCC66);
    cyc(1);
    check("blank_black", {VGA_R, VGA_G, VGA_B}, 32'h0);
    cyc(1);
    check("blank_after", {VGA_R, VGA_G, VGA_B}, 32'hFFCC66);

    // Palette write while the entry is being displayed.
    pal_addr = 4'd3; pal_rgb = 24'h123456; pal_we = 1'b1;
    cyc(1);
    pal_we = 1'b0;
    check("pal_same_cycle_old", {VGA_R, VGA_G, VGA_B}, 32'hFFCC66);
    cyc(1);
    check("pal_new_value", {VGA_R, VGA_G, VGA_B}, 32'h123456);

    // Clear start with a coincident write, then reset at clear count 100.
    put_pal(9, 24'h999999);
    wr_x = CW'(5); wr_y = CW'(10); wr_idx = 4'd2; wr_valid = 1'b1;
    clr_idx = 4'd9; clr_start = 1'b1;
    cyc(1);
    wr_valid = 1'b0; clr_start = 1'b0;
    check("clr_with_write_ready", wr_ready, 32'd0);
    cyc(100);
    Reset_n = 1'b0;
    #1;
    check("abort_busy", clr_busy, 32'd0);
    check("abort_rgb", {VGA_R, VGA_G, VGA_B}, 32'h0);
    cyc(2);
    Reset_n = 1'b1;
    cyc(1);
    put_pal(9, 24'h999999);
    put_pal(5, 24'h0055AA);
    put_pal(2, 24'h222222);
    expect_pix(3, 3, 24'h999999, "abort_pixel_99");
    expect_pix(4, 3, 24'h0055AA, "abort_pixel_100");
    expect_pix(5, 10, 24'h222222, "coincident_write");

    // Swap inputs are inert in the single-bank build.
    pulse_swap(1'b1, 1'b1);
    check("single_no_pending", swap_pending, 32'd0);
    expect_pix(5, 10, 24'h222222, "single_no_swap");
`else
    // Bring both banks to a known state.
    put_pal(0, 24'h010203);
    start_clear(0);
    wait_idle(n);
    check("db_clear_cycles", n, DEPTH);
    pulse_swap(1'b1, 1'b1);
    check("db_same_cycle_swap", swap_pending, 32'd0);
    start_clear(0);
    wait_idle(n);

    // Draw into the back bank, then swap it to the front.
    put_pal(7, 24'hABCDEF);
    put_pix(0, 0, 7);
    expect_pix(0, 0, 24'h010203, "db_back_hidden");
    pulse_swap(1'b1, 1'b0);
    check("db_pending_set", swap_pending, 32'd1);
    pulse_swap(1'b0, 1'b1);
    check("db_pending_clear", swap_pending, 32'd0);
    expect_pix(0, 0, 24'hABCDEF, "db_swapped");

    // A swap requested during a clear waits for frame_start after the clear.
    start_clear(0);
    pulse_swap(1'b1, 1'b0);
    pulse_swap(1'b0, 1'b1);
    check("db_deferred_pending", swap_pending, 32'd1);
    wait_idle(n);
    expect_pix(0, 0, 24'hABCDEF, "db_deferred_front");
    check("db_still_pending", swap_pending, 32'd1);
    pulse_swap(1'b0, 1'b1);
    check("db_deferred_done", swap_pending, 32'd0);
    expect_pix(0, 0, 24'h010203, "db_deferred_swapped");
`endif

    cyc(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
